// File: rtl/sdcard_spi_target.sv
// SPI mode-0 target byte engine, oversampled on clk, MSB first.
// Define SDCARD_SPI_TARGET_CRC_EN to enable the receive CRC16.
module sdcard_spi_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        cs_n,
  output logic        miso,
  output logic        miso_oe,
  input  logic [7:0]  tx_data,
  input  logic        tx_load,
  output logic        tx_ready,
  output logic        tx_taken,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        selected,
  input  logic        crc_clear,
  output logic [15:0] crc_out
);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t state;
  state_t state_n;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic sclk_d;
  logic sclk_s;
  logic mosi_s;
  logic cs_s;

  logic [2:0] bit_cnt;
  logic [7:0] shifter;
  logic [6:0] shift_in;
  logic [7:0] hold_q;
  logic       hold_valid;

  logic enter;
  logic leave;
  logic rise_act;
  logic fall_act;
  logic consume;
  logic take;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];

  // Bring the initiator's pins into the clk domain, idle levels at reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_sync <= '0;
      mosi_sync <= '1;
      cs_sync   <= '1;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sclk_d    <= sclk_s;
    end
  end

  // Selection state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next state plus edge qualification; edges only count while selected.
  always_comb begin
    state_n  = state;
    enter    = 1'b0;
    leave    = 1'b0;
    rise_act = 1'b0;
    fall_act = 1'b0;
    unique case (state)
      IDLE: begin
        if (!cs_s) begin
          state_n = ACTIVE;
          enter   = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_s) begin
          state_n = IDLE;
          leave   = 1'b1;
        end else begin
          rise_act = sclk_s & ~sclk_d;
          fall_act = ~sclk_s & sclk_d;
        end
      end
      default: state_n = IDLE;
    endcase
    consume = enter | (fall_act & (bit_cnt == 3'd0));
    take    = consume & hold_valid;
  end

  // Shift engine, receive capture and the one-byte holding buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt    <= 3'd0;
      shifter    <= IDLE_BYTE;
      shift_in   <= 7'd0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      tx_taken   <= 1'b0;
      hold_q     <= 8'h00;
      hold_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_taken <= take;
      if (consume)
        shifter <= hold_valid ? hold_q : IDLE_BYTE;
      else if (fall_act)
        shifter <= {shifter[6:0], 1'b1};
      if (enter || leave) begin
        bit_cnt <= 3'd0;
      end else if (rise_act) begin
        shift_in <= {shift_in[5:0], mosi_s};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_data  <= {shift_in, mosi_s};
          rx_valid <= 1'b1;
        end
      end
      if (take) begin
        hold_valid <= tx_load;
        if (tx_load) hold_q <= tx_data;
      end else if (tx_load && !hold_valid) begin
        hold_q     <= tx_data;
        hold_valid <= 1'b1;
      end
    end
  end

  assign miso     = (state == ACTIVE) ? shifter[7] : 1'b1;
  assign miso_oe  = (state == ACTIVE);
  assign tx_ready = ~hold_valid;
  assign selected = ~cs_s;

`ifdef SDCARD_SPI_TARGET_CRC_EN
  logic [15:0] crc_q;

  // CRC16-CCITT over every received bit; clear wins over a new bit.
  always_ff @(posedge clk) begin
    if (!rst)
      crc_q <= 16'h0000;
    else if (crc_clear)
      crc_q <= 16'h0000;
    else if (rise_act)
      crc_q <= {crc_q[14:0], 1'b0}
             ^ ({16{crc_q[15] ^ mosi_s}} & 16'h1021);
  end

  assign crc_out = crc_q;
`else
  logic crc_unused;

  assign crc_unused = crc_clear;
  assign crc_out    = 16'h0000;
`endif

endmodule

// File: tb/tb_sdcard_spi_target.sv
// Bench for sdcard_spi_target: acts as SPI initiator and checks
// the target against a transaction-level model of bytes in/out.
module tb_sdcard_spi_target;

  localparam int SS = 2;

`ifdef SDCARD_SPI_TARGET_CRC_EN
  localparam logic [15:0] CRC_FF512 = 16'h7FA1;
`else
  localparam logic [15:0] CRC_FF512 = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sclk = 1'b0;
  logic        mosi = 1'b1;
  logic        cs_n = 1'b1;
  logic        miso;
  logic        miso_oe;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_load = 1'b0;
  logic        tx_ready;
  logic        tx_taken;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        selected;
  logic        crc_clear = 1'b0;
  logic [15:0] crc_out;

  sdcard_spi_target #(
    .SYNC_STAGES(SS),
    .IDLE_BYTE  (8'hFF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .mosi     (mosi),
    .cs_n     (cs_n),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_ready (tx_ready),
    .tx_taken (tx_taken),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .selected (selected),
    .crc_clear(crc_clear),
    .crc_out  (crc_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int half = 6;
  bit chk_en = 1'b0;

  logic [7:0]  m_hold = 8'h00;
  bit          m_hold_v = 1'b0;
  logic [7:0]  m_cur = 8'hFF;
  int          m_taken_exp = 0;
  int          taken_seen = 0;
  logic [7:0]  exp_rx[$];
  logic [7:0]  m_rx = 8'h00;
  logic [15:0] m_crc = 16'h0000;
  logic [7:0]  mi;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c,
                                           input logic b);
    logic [15:0] r;
    r = {c[14:0], 1'b0};
    if (c[15] ^ b) r = r ^ 16'h1021;
    return r;
  endfunction

  function automatic logic [15:0] crc_exp();
`ifdef SDCARD_SPI_TARGET_CRC_EN
    return m_crc;
`else
    return 16'h0000;
`endif
  endfunction

  // Byte the target must shift out next: pending buffer or idle byte.
  task automatic next_out(output logic [7:0] b);
    if (m_hold_v) begin
      b = m_hold;
      m_hold_v = 1'b0;
      m_taken_exp++;
    end else begin
      b = 8'hFF;
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    tx_data = v;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    if (!m_hold_v) begin
      m_hold = v;
      m_hold_v = 1'b1;
    end
  endtask

  task automatic select();
    cs_n = 1'b0;
    next_out(m_cur);
    repeat (8) @(negedge clk);
  endtask

  task automatic deselect();
    repeat (half) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] mo, input int nb,
                      input bit ld, input logic [7:0] ldv,
                      output logic [7:0] got);
    got = 8'hFF;
    if (nb == 8) exp_rx.push_back(mo);
    for (int k = 0; k < nb; k++) begin
      mosi = mo[7-k];
      repeat (half) @(negedge clk);
      sclk = 1'b1;
      got[7-k] = miso;
      m_crc = crc_step(m_crc, mo[7-k]);
      repeat (half) @(negedge clk);
      sclk = 1'b0;
    end
    if (nb == 8) begin
      chk("miso_byte", got, m_cur);
      next_out(m_cur);
      if (ld) begin
        repeat (SS) @(negedge clk);
        tx_data = ldv;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        m_hold = ldv;
        m_hold_v = 1'b1;
        chk("taken_same_cycle", tx_taken, 1);
        chk("ready_same_cycle", tx_ready, 0);
      end
    end
  endtask

  bit prev_rxv = 1'b0;
  logic cs_prev = 1'b1;
  int cs_cnt = 0;

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      if (tx_taken === 1'b1) taken_seen++;
      if (rx_valid === 1'b1) begin
        chk("rx_valid_expected", exp_rx.size() != 0, 1);
        if (exp_rx.size() != 0) m_rx = exp_rx.pop_front();
        chk("rx_valid_width", prev_rxv, 0);
      end
      prev_rxv = (rx_valid === 1'b1);
      chk("rx_data", rx_data, m_rx);
      if (cs_n === cs_prev) cs_cnt++;
      else cs_cnt = 0;
      cs_prev = cs_n;
      if (cs_cnt >= SS + 2) begin
        chk("selected", selected, !cs_n);
        chk("miso_oe", miso_oe, !cs_n);
      end
      if (miso_oe === 1'b0) chk("miso_idle", miso, 1);
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_miso", miso, 1);
    chk("rst_miso_oe", miso_oe, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_tx_taken", tx_taken, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_selected", selected, 0);
    chk("rst_crc", crc_out, 16'h0000);
    rst = 1'b1;
    chk_en = 1'b1;
    repeat (10) @(negedge clk);

    do_load(8'hA5);
    chk("ready_after_load", tx_ready, 0);
    select();
    chk("taken_at_select", taken_seen, m_taken_exp);
    chk("ready_after_take", tx_ready, 1);
    xfer(8'h3C, 8, 1'b0, 8'h00, mi);
    chk("first_byte_a5", mi, 8'hA5);
    deselect();
    chk("rx_3c", rx_data, 8'h3C);

    do_load(8'h12);
    select();
    chk("ready_burst", tx_ready, 1);
    xfer(8'h81, 8, 1'b0, 8'h00, mi);
    chk("burst_b0_12", mi, 8'h12);
    xfer(8'h7E, 8, 1'b0, 8'h00, mi);
    chk("burst_b1_ff", mi, 8'hFF);
    deselect();
    chk("rx_7e", rx_data, 8'h7E);
    chk("rx_all_seen", exp_rx.size(), 0);

    select();
    xfer(8'hF0, 5, 1'b0, 8'h00, mi);
    deselect();
    chk("abort_oe", miso_oe, 0);
    chk("abort_miso", miso, 1);
    chk("abort_rx_kept", rx_data, 8'h7E);
    for (int i = 0; i < 3; i++) begin
      repeat (half) @(negedge clk);
      sclk = 1'b1;
      repeat (half) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (8) @(negedge clk);
    select();
    xfer(8'hC3, 8, 1'b0, 8'h00, mi);
    deselect();
    chk("rx_c3", rx_data, 8'hC3);

    select();
    do_load(8'hAA);
    xfer(8'h11, 8, 1'b1, 8'h55, mi);
    chk("race_b0_ff", mi, 8'hFF);
    xfer(8'h22, 8, 1'b0, 8'h00, mi);
    chk("race_b1_aa", mi, 8'hAA);
    repeat (SS + 2) @(negedge clk);
    chk("ready_after_55", tx_ready, 1);
    xfer(8'h33, 8, 1'b0, 8'h00, mi);
    chk("race_b2_55", mi, 8'h55);
    deselect();
    chk("taken_count", taken_seen, m_taken_exp);
    chk("rx_33", rx_data, 8'h33);

    chk("crc_history", crc_out, crc_exp());
    crc_clear = 1'b1;
    @(negedge clk);
    crc_clear = 1'b0;
    m_crc = 16'h0000;
    @(negedge clk);
    chk("crc_cleared", crc_out, 16'h0000);
    half = 4;
    select();
    for (int i = 0; i < 512; i++) xfer(8'hFF, 8, 1'b0, 8'h00, mi);
    deselect();
    chk("crc_model", crc_out, crc_exp());
    chk("crc_ff512", crc_out, CRC_FF512);
    chk("rx_ff", rx_data, 8'hFF);
    chk("rx_queue_empty", exp_rx.size(), 0);
    chk("taken_final", taken_seen, m_taken_exp);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
